// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the IF/MEM memory port arbiter: bus widths, arbiter state codes
// and the default watchdog limit.
package mem_port_arbiter_pkg;

  localparam int unsigned RegBus            = 32;
  localparam int unsigned ArbTimeoutDefault = 255;

  localparam logic [3:0] SelAll = 4'hF;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ArbIdle = 2'd0;
  localparam arb_state_t ArbData = 2'd1;
  localparam arb_state_t ArbInst = 2'd2;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// System-bus side of the arbiter: one registered request channel and its ack/read data.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        sel;
  logic              ack;
  logic [31:0]       rdata;

  modport master (
    output req, we, addr, wdata, sel,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, sel,
    output ack, rdata
  );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Cycle counter for an in-flight bus transaction; flags a timeout when the transaction
// has gone TIMEOUT_CYCLES cycles without an ack.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  input  logic active_i,
  input  logic ack_i,
  output logic timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Saturates rather than wraps so a stuck bus can never look fresh again.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (active_i && !ack_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the last allowed cycle; an ack in that same cycle suppresses it.
  assign timeout_o = active_i & ~ack_i & (cnt_q == (CntMax - 1'b1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one multi-cycle memory bus between instruction fetch and data access, with a
// one-entry fetch hold register and a watchdog that abandons stuck transactions.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = ArbTimeoutDefault,
  parameter int unsigned ADDR_W         = RegBus
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_data_o,
  output logic              if_ready_o,

  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  input  logic [3:0]        mem_sel_i,
  input  logic              mem_hold_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ready_o,

  output logic              stallreq_o,

  mem_port_arbiter_if.master bus,
  output logic              bus_err_o
);

  arb_state_t        state_q, state_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic [3:0]        bus_sel_q, bus_sel_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic              data_done_q, data_done_d;
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]       hold_data_q, hold_data_d;
  logic              err_q, err_d;

  logic data_pend, inst_pend, wd_start, wd_active, timeout;

  assign if_ready_o = if_ce_i & hold_valid_q & (hold_addr_q == if_addr_i);
  assign data_pend  = mem_ce_i & ~data_done_q;
  assign inst_pend  = if_ce_i & ~if_ready_o;
  assign wd_active  = (state_q != ArbIdle);
  assign wd_start   = (state_q == ArbIdle) & (data_pend | inst_pend);

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk_i     (clk),
    .rst_ni    (rst),
    .start_i   (wd_start),
    .active_i  (wd_active),
    .ack_i     (bus.ack),
    .timeout_o (timeout)
  );

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_sel_d    = bus_sel_q;
    mem_data_d   = mem_data_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    err_d        = err_q;
    // Completion is kept until the MEM stage actually moves on, so a stall from IF
    // cannot cause the same load/store to be issued twice.
    data_done_d  = data_done_q & mem_hold_i;

    case (state_q)
      ArbIdle: begin
        if (data_pend) begin
          state_d     = ArbData;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_data_i;
          bus_sel_d   = mem_sel_i;
        end else if (inst_pend) begin
          state_d     = ArbInst;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = '0;
          bus_sel_d   = SelAll;
        end
      end
      ArbData: begin
        if (bus.ack || timeout) begin
          state_d     = ArbIdle;
          bus_req_d   = 1'b0;
          data_done_d = 1'b1;
          if (!bus.ack) begin
            mem_data_d = '0;
            err_d      = 1'b1;
          end else if (!bus_we_q) begin
            mem_data_d = bus.rdata;
          end else if (bus_addr_q[ADDR_W-1:2] == hold_addr_q[ADDR_W-1:2]) begin
            hold_valid_d = 1'b0;
          end
        end
      end
      ArbInst: begin
        if (bus.ack || timeout) begin
          state_d      = ArbIdle;
          bus_req_d    = 1'b0;
          hold_valid_d = 1'b1;
          hold_addr_d  = bus_addr_q;
          // A timed-out fetch returns all-zero rather than stale data.
          hold_data_d  = bus.ack ? bus.rdata : '0;
          if (!bus.ack) begin
            err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ArbIdle;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ArbIdle;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_sel_q    <= '0;
      mem_data_q   <= '0;
      data_done_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_sel_q    <= bus_sel_d;
      mem_data_q   <= mem_data_d;
      data_done_q  <= data_done_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.req     = bus_req_q;
  assign bus.we      = bus_we_q;
  assign bus.addr    = bus_addr_q;
  assign bus.wdata   = bus_wdata_q;
  assign bus.sel     = bus_sel_q;
  assign bus_err_o   = err_q;
  assign if_data_o   = hold_data_q;
  assign mem_data_o  = mem_data_q;
  assign mem_ready_o = data_done_q;
  // Gated by reset so every output reads zero while the block is held in reset.
  assign stallreq_o  = rst & ((if_ce_i & ~if_ready_o) | (mem_ce_i & ~data_done_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small bus model with a programmable ack delay
// drives the system side while the core side is stepped through hand-computed scenarios.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_ce = 1'b0, mem_ce = 1'b0, mem_we = 1'b0, mem_hold = 1'b0;
  logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
  logic [3:0]  mem_sel = '0;
  logic [31:0] if_data, mem_data;
  logic        if_ready, mem_ready, stallreq, bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (8),
    .ADDR_W         (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_ce_i     (if_ce),
    .if_addr_i   (if_addr),
    .if_data_o   (if_data),
    .if_ready_o  (if_ready),
    .mem_ce_i    (mem_ce),
    .mem_we_i    (mem_we),
    .mem_addr_i  (mem_addr),
    .mem_data_i  (mem_wdata),
    .mem_sel_i   (mem_sel),
    .mem_hold_i  (mem_hold),
    .mem_data_o  (mem_data),
    .mem_ready_o (mem_ready),
    .stallreq_o  (stallreq),
    .bus         (bus),
    .bus_err_o   (bus_err)
  );

  // Bus model: acks ack_wait cycles after req rises, logs every issued address.
  bit          ack_en = 1'b1;
  int          ack_wait = 0;
  int          wait_cnt = 0;
  bit          req_d = 1'b0;
  int          n_txn = 0;
  int          n_req_cyc = 0;
  logic [31:0] issue_log[$];
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] st_data = '0;
  logic [3:0]  st_sel = '0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : (a ^ 32'hA5A5_0000);
  endfunction

  always @(negedge clk) begin
    bus.ack = 1'b0;
    if (!bus.req) begin
      req_d = 1'b0;
    end else begin
      if (!req_d) begin
        wait_cnt = 0;
        n_txn++;
        issue_log.push_back(bus.addr);
      end else begin
        wait_cnt++;
      end
      req_d = 1'b1;
      n_req_cyc++;
      if (ack_en && (wait_cnt == ack_wait)) begin
        bus.ack   = 1'b1;
        bus.rdata = rd(bus.addr);
        if (bus.we) begin
          mem_model[bus.addr] = bus.wdata;
          st_data = bus.wdata;
          st_sel  = bus.sel;
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles with stallreq high, bounded so a stuck DUT cannot hang the run.
  task automatic wait_stall(input string tag, input int exp);
    int n = 0;
    #1;
    while (stallreq && (n < 40)) begin
      step();
      n++;
    end
    check_eq(tag, n, exp);
  endtask

  function automatic logic [31:0] logged(input int i);
    return (issue_log.size() > i) ? issue_log[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic release_mem();
    mem_hold = 1'b0;
    step();
    mem_ce = 1'b0;
    mem_we = 1'b0;
    if_ce  = 1'b0;
    step();
  endtask

  initial begin
    int base, lbase;
    mem_model[32'h0000_0100] = 32'h0000_0013;
    mem_model[32'h0000_0104] = 32'h0010_0093;
    mem_model[32'h0000_2000] = 32'hCAFE_0001;

    // Reset: all outputs zero even with requests present.
    if_ce = 1'b1; mem_ce = 1'b1; if_addr = 32'h100; mem_addr = 32'h2000;
    #2;
    check_eq("rst_bus_req", bus.req, 0);
    check_eq("rst_stallreq", stallreq, 0);
    check_eq("rst_if_ready", if_ready, 0);
    check_eq("rst_mem_ready", mem_ready, 0);
    check_eq("rst_bus_err", bus_err, 0);
    check_eq("rst_bus_addr", bus.addr, 0);
    if_ce = 1'b0; mem_ce = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    step();

    // 1: fetch miss, zero-wait bus.
    base = n_txn;
    if_ce = 1'b1; if_addr = 32'h100;
    wait_stall("t1_stall", 2);
    check_eq("t1_if_ready", if_ready, 1);
    check_eq("t1_if_data", if_data, 32'h13);
    step();
    check_eq("t1_hit_ready", if_ready, 1);
    check_eq("t1_txn", n_txn - base, 1);

    // 2: simultaneous IF miss and MEM load; data goes first.
    base = n_txn; lbase = issue_log.size();
    if_addr = 32'h104; mem_ce = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000; mem_hold = 1'b1;
    wait_stall("t2_stall", 4);
    check_eq("t2_first_addr", logged(lbase), 32'h2000);
    check_eq("t2_second_addr", logged(lbase + 1), 32'h104);
    check_eq("t2_mem_data", mem_data, 32'hCAFE_0001);
    check_eq("t2_if_data", if_data, 32'h0010_0093);
    check_eq("t2_mem_ready", mem_ready, 1);
    release_mem();
    check_eq("t2_mem_ready_clr", mem_ready, 0);
    check_eq("t2_txn", n_txn - base, 2);

    // 3: load completes, then MEM held 3 more cycles.
    base = n_txn;
    mem_ce = 1'b1; mem_addr = 32'h3000; mem_hold = 1'b1;
    wait_stall("t3_stall", 2);
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_ready_held", mem_ready, 1);
      step();
    end
    mem_hold = 1'b0;
    #1;
    check_eq("t3_ready_before_edge", mem_ready, 1);
    step();
    mem_ce = 1'b0;
    #1;
    check_eq("t3_ready_clr", mem_ready, 0);
    check_eq("t3_mem_data", mem_data, 32'hA5A5_3000);
    step();
    check_eq("t3_txn", n_txn - base, 1);

    // 4: refill 0x100, then store to it; the hold entry must be invalidated.
    if_ce = 1'b1; if_addr = 32'h100;
    wait_stall("t4_refill_stall", 2);
    check_eq("t4_refill_data", if_data, 32'h13);
    base = n_txn;
    mem_ce = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF;
    mem_sel = 4'hF; mem_hold = 1'b1;
    wait_stall("t4_stall", 4);
    check_eq("t4_st_data", st_data, 32'hDEAD_BEEF);
    check_eq("t4_st_sel", st_sel, 4'hF);
    check_eq("t4_refetch_data", if_data, 32'hDEAD_BEEF);
    check_eq("t4_txn", n_txn - base, 2);
    check_eq("t4_mem_data_kept", mem_data, 32'hA5A5_3000);
    release_mem();

    // Ack in the last allowed cycle wins over the timeout.
    ack_wait = 7;
    base = n_req_cyc;
    mem_ce = 1'b1; mem_addr = 32'h2000; mem_hold = 1'b1;
    wait_stall("edge_stall", 9);
    check_eq("edge_req_cycles", n_req_cyc - base, 8);
    check_eq("edge_bus_err", bus_err, 0);
    check_eq("edge_mem_data", mem_data, 32'hCAFE_0001);
    release_mem();
    ack_wait = 0;

    // 5: no ack at all, data then instruction.
    ack_en = 1'b0;
    base = n_req_cyc;
    mem_ce = 1'b1; mem_addr = 32'h4000; mem_hold = 1'b1;
    wait_stall("t5_stall", 9);
    check_eq("t5_req_cycles", n_req_cyc - base, 8);
    check_eq("t5_bus_err", bus_err, 1);
    check_eq("t5_mem_ready", mem_ready, 1);
    check_eq("t5_mem_data", mem_data, 0);
    release_mem();
    if_ce = 1'b1; if_addr = 32'h500;
    wait_stall("t5_inst_stall", 9);
    check_eq("t5_if_ready", if_ready, 1);
    check_eq("t5_if_data", if_data, 0);
    if_ce = 1'b0;
    repeat (3) step();
    check_eq("t5_err_sticky", bus_err, 1);

    // 6: reset asserted in the middle of a data transaction.
    mem_ce = 1'b1; mem_addr = 32'h6000; mem_hold = 1'b1;
    step();
    step();
    check_eq("t6_req_before", bus.req, 1);
    #2;
    rst = 1'b0;
    #1;
    check_eq("t6_bus_req", bus.req, 0);
    check_eq("t6_bus_err", bus_err, 0);
    check_eq("t6_stallreq", stallreq, 0);
    check_eq("t6_mem_ready", mem_ready, 0);
    check_eq("t6_bus_addr", bus.addr, 0);
    mem_ce = 1'b0; mem_hold = 1'b0; ack_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
    if_ce = 1'b1; if_addr = 32'h100;
    wait_stall("t6_restart_stall", 2);
    check_eq("t6_restart_data", if_data, 32'hDEAD_BEEF);
    if_ce = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
